seg7_source_sched: RTL and testbench

//  Memory-mapped controller that decides what 32-bit word the 8-digit seg7x16 driver shows.

---
 rtl/seg7_source_sched.sv | 107 ++++++++++
 tb/tb_seg7_source_sched.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/seg7_source_sched.sv
// Display source scheduler for the seg7x16 driver: MMIO register file plus a
// MANUAL/AUTO/HOLD controller choosing which 32-bit word the display shows.
module seg7_source_sched #(
  parameter logic [31:0] DWELL_RST = 32'd50_000_000,
  parameter logic [31:0] DATA_RST  = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        bus_we,
  input  logic        bus_re,
  input  logic [1:0]  bus_addr,
  input  logic [31:0] bus_wdata,
  output logic [31:0] bus_rdata,
  input  logic [31:0] src_pc,
  input  logic [31:0] src_instr,
  input  logic [31:0] src_dbg,
  output logic [31:0] disp_data,
  output logic [1:0]  disp_src,
  output logic        disp_update
);

  // state  | meaning
  // MANUAL | display follows CTRL.sel, live
  // AUTO   | rotate sources every DWELL cycles, live
  // HOLD   | display word and index frozen
  typedef enum logic [1:0] {MANUAL, AUTO, HOLD} stateT;

  stateT       state, stateNext;
  logic [31:0] dataReg, dwellReg, dwellCnt, cntNext, dispNext;
  logic [3:0]  ctrlReg, ctrlNext;
  logic [1:0]  srcNext, srcPrev;
  logic        cfgWr;

  always_comb begin
    ctrlNext  = ctrlReg;
    if (bus_we && bus_addr == 2'd1) ctrlNext = bus_wdata[3:0];
    cfgWr     = bus_we && (bus_addr == 2'd1 || bus_addr == 2'd2);
    stateNext = MANUAL;
    if (ctrlNext[3])      stateNext = HOLD;
    else if (ctrlNext[2]) stateNext = AUTO;
    srcNext = disp_src;
    cntNext = '0;
    case (stateNext)
      MANUAL: srcNext = ctrlNext[1:0];
      AUTO: begin
        if (state != AUTO) begin
          srcNext = ctrlNext[1:0];
        end else if (cfgWr) begin
          cntNext = '0;
        end else if (dwellCnt == dwellReg - 32'd1) begin
          srcNext = disp_src + 2'd1;
        end else begin
          cntNext = dwellCnt + 32'd1;
        end
      end
      default: ;
    endcase
    case (srcNext)
      2'd0:    dispNext = dataReg;
      2'd1:    dispNext = src_pc;
      2'd2:    dispNext = src_instr;
      default: dispNext = src_dbg;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      dataReg     <= DATA_RST;
      ctrlReg     <= '0;
      dwellReg    <= DWELL_RST;
      dwellCnt    <= '0;
      state       <= MANUAL;
      disp_data   <= DATA_RST;
      disp_src    <= '0;
      srcPrev     <= '0;
      disp_update <= 1'b0;
      bus_rdata   <= '0;
    end else begin
      if (bus_we) begin
        case (bus_addr)
          2'd0:    dataReg  <= bus_wdata;
          2'd1:    ctrlReg  <= bus_wdata[3:0];
          2'd2:    dwellReg <= (bus_wdata == 32'd0) ? 32'd1 : bus_wdata;
          default: ;
        endcase
      end
      // Reads see the registers as they were before this cycle's write.
      if (bus_re) begin
        case (bus_addr)
          2'd0:    bus_rdata <= dataReg;
          2'd1:    bus_rdata <= {28'd0, ctrlReg};
          2'd2:    bus_rdata <= dwellReg;
          default: bus_rdata <= {28'd0, state == AUTO, state == HOLD, disp_src};
        endcase
      end
      state    <= stateNext;
      dwellCnt <= cntNext;
      if (stateNext != HOLD) begin
        disp_src  <= srcNext;
        disp_data <= dispNext;
      end
      srcPrev     <= disp_src;
      disp_update <= (disp_src != srcPrev) && (stateNext != HOLD);
    end
  end

endmodule

// File: tb/tb_seg7_source_sched.sv
// Scoreboard bench for seg7_source_sched: expected display updates and read
// data are queued by the stimulus and checked by separate monitor processes.
module tb_seg7_source_sched;

  localparam logic [31:0] PC  = 32'h0040_0010;
  localparam logic [31:0] IN1 = 32'hDEAD_0002;
  localparam logic [31:0] IN2 = 32'h1111_2222;
  localparam logic [31:0] DBG = 32'hDB60_0003;
  localparam logic [31:0] DV  = 32'h5555_AAAA;

  logic        CLK, RST;
  logic        bus_we, bus_re;
  logic [1:0]  bus_addr;
  logic [31:0] bus_wdata, bus_rdata;
  logic [31:0] src_pc, src_instr, src_dbg;
  logic [31:0] disp_data;
  logic [1:0]  disp_src;
  logic        disp_update;

  typedef struct {logic [1:0] src; logic [31:0] data; int gap;} updT;
  updT         updQ[$];
  logic [31:0] rdQ[$];
  int          checks = 0, failures = 0;
  int          cyc = 0, lastPulse = 0;
  logic        rdPend = 1'b0, monEn = 1'b1;

  seg7_source_sched dut (
    .CLK(CLK), .RST(RST), .bus_we(bus_we), .bus_re(bus_re),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
    .src_pc(src_pc), .src_instr(src_instr), .src_dbg(src_dbg),
    .disp_data(disp_data), .disp_src(disp_src), .disp_update(disp_update)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cyc    <= cyc + 1;
    rdPend <= bus_re;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Display-update monitor
  always @(negedge CLK) begin
    if (!RST && monEn && disp_update) begin
      if (updQ.size() == 0) begin
        chk("spurious_update", 32'd1, 32'd0);
      end else begin
        updT e;
        e = updQ.pop_front();
        chk("upd_src", {30'd0, disp_src}, {30'd0, e.src});
        chk("upd_data", disp_data, e.data);
        if (e.gap != 0) chk("upd_gap", cyc - lastPulse, e.gap);
      end
      lastPulse = cyc;
    end
  end

  // Read-data monitor
  always @(negedge CLK) begin
    if (!RST && rdPend) begin
      if (rdQ.size() == 0) chk("spurious_read", 32'd1, 32'd0);
      else chk("rdata", bus_rdata, rdQ.pop_front());
    end
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge CLK);
    bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    @(negedge CLK);
    bus_we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] exp);
    rdQ.push_back(exp);
    @(negedge CLK);
    bus_re = 1'b1; bus_addr = a;
    @(negedge CLK);
    bus_re = 1'b0;
  endtask

  task automatic pushUpd(input logic [1:0] s, input logic [31:0] d, input int g);
    updT e;
    e.src = s; e.data = d; e.gap = g;
    updQ.push_back(e);
  endtask

  task automatic drainUpd(input string name);
    int n = 0;
    while (updQ.size() != 0 && n < 100) begin
      @(negedge CLK);
      n++;
    end
    chk(name, updQ.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  seqSrc[5];
    logic [31:0] seqData[5];
    RST = 1'b1; bus_we = 1'b0; bus_re = 1'b0; bus_addr = '0; bus_wdata = '0;
    src_pc = PC; src_instr = IN1; src_dbg = DBG;
    repeat (3) @(negedge CLK);
    chk("rst_disp_data", disp_data, 32'd0);
    chk("rst_disp_src", {30'd0, disp_src}, 32'd0);
    chk("rst_disp_update", {31'd0, disp_update}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    RST = 1'b0;
    rd(2'd3, 32'd0);

    // DATA write reaches the display two cycles later
    wr(2'd0, 32'h1234_ABCD);
    @(negedge CLK);
    chk("data_disp", disp_data, 32'h1234_ABCD);
    // Simultaneous write/read of DATA returns the old value
    rdQ.push_back(32'h1234_ABCD);
    @(negedge CLK);
    bus_we = 1'b1; bus_re = 1'b1; bus_addr = 2'd0; bus_wdata = DV;
    @(negedge CLK);
    bus_we = 1'b0; bus_re = 1'b0;
    rd(2'd0, DV);

    // Manual select of PC
    pushUpd(2'd1, PC, 0);
    wr(2'd1, 32'd1);
    repeat (5) @(negedge CLK);
    chk("manual_upd_count", updQ.size(), 32'd0);
    chk("manual_src", {30'd0, disp_src}, 32'd1);
    chk("manual_data", disp_data, PC);

    // Auto rotation with DWELL=4
    wr(2'd2, 32'd4);
    rd(2'd2, 32'd4);
    pushUpd(2'd0, DV, 0);
    pushUpd(2'd1, PC, 4);
    pushUpd(2'd2, IN1, 4);
    pushUpd(2'd3, DBG, 4);
    pushUpd(2'd0, DV, 4);
    pushUpd(2'd1, PC, 4);
    pushUpd(2'd2, IN1, 4);
    wr(2'd1, 32'h4);
    drainUpd("auto_drain");

    // Freeze while showing src 2
    wr(2'd1, 32'hC);
    chk("hold_src", {30'd0, disp_src}, 32'd2);
    chk("hold_data", disp_data, IN1);
    src_instr = IN2;
    wr(2'd0, 32'hFFFF_FFFF);
    repeat (3) @(negedge CLK);
    chk("hold_data_after", disp_data, IN1);
    chk("hold_src_after", {30'd0, disp_src}, 32'd2);
    chk("hold_no_update", {31'd0, disp_update}, 32'd0);
    rd(2'd3, 32'd6);
    rd(2'd0, 32'hFFFF_FFFF);
    rd(2'd1, 32'hC);

    // DWELL=0 stored as 1: advance every cycle
    wr(2'd2, 32'd0);
    rd(2'd2, 32'd1);
    monEn = 1'b0;
    wr(2'd1, 32'h4);
    seqSrc[0] = 2'd0; seqData[0] = 32'hFFFF_FFFF;
    seqSrc[1] = 2'd1; seqData[1] = PC;
    seqSrc[2] = 2'd2; seqData[2] = IN2;
    seqSrc[3] = 2'd3; seqData[3] = DBG;
    seqSrc[4] = 2'd0; seqData[4] = 32'hFFFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      chk("fast_src", {30'd0, disp_src}, {30'd0, seqSrc[i]});
      chk("fast_data", disp_data, seqData[i]);
      if (i >= 2) chk("fast_update", {31'd0, disp_update}, 32'd1);
      @(negedge CLK);
    end

    // Asynchronous reset in the middle of a dwell period
    wr(2'd2, 32'd10);
    repeat (3) @(negedge CLK);
    #2 RST = 1'b1;
    #1;
    chk("arst_disp_data", disp_data, 32'd0);
    chk("arst_disp_src", {30'd0, disp_src}, 32'd0);
    chk("arst_disp_update", {31'd0, disp_update}, 32'd0);
    chk("arst_rdata", bus_rdata, 32'd0);
    @(negedge CLK);
    RST = 1'b0;
    rd(2'd0, 32'd0);
    rd(2'd1, 32'd0);
    rd(2'd2, 32'd50_000_000);
    rd(2'd3, 32'd0);
    repeat (3) @(negedge CLK);
    chk("rd_drain", rdQ.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
